// File: rtl/conv_layer_window_feeder.sv
// conv_layer_window_feeder: fetches image rows into a KxI rolling line buffer and streams KxK window shifts plus a bias cycle
module conv_layer_window_feeder #(
  parameter int WIDTH = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_SIZE = 8,
  parameter int ARRAY_SIZE = 6,
  parameter int ADDR_WIDTH = 6,
  parameter logic [WIDTH-1:0] BIAS_VALUE = WIDTH'(32'h3F800000)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [1:0]                  cmd,
  input  logic [WIDTH-1:0]            pixel_in,
  output logic [1:0]                  ack,
  output logic [2:0]                  current_state,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  output logic                        out_valid,
  output logic [2:0]                  win_row,
  output logic [2:0]                  win_col,
  output logic                        image_done,
  output logic [ARRAY_SIZE*WIDTH-1:0] out_kernel_port
);
  localparam int K = KERNEL_SIZE;
  localparam int I = IMAGE_SIZE;
  localparam int W = WIDTH;
  localparam int CW = $clog2(K * I + 1);
  localparam int CLW = $clog2(I);
  localparam int RW = $clog2(I + 1);
  localparam int KW = $clog2(K);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(I * I - 1);

  if (ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) begin : g_bad_array
    $error("ARRAY_SIZE must equal IMAGE_SIZE-KERNEL_SIZE+1");
  end

  typedef enum logic [2:0] {INIT = 3'd0, PRELOAD = 3'd1, SHIFT = 3'd2, BIAS = 3'd3, LOAD = 3'd4, IDLE = 3'd5} state_t;

  state_t state, state_n;
  logic [I*W-1:0] buffer [K];
  logic [I*W-1:0] sr, sr_n;
  logic [CW-1:0] cnt, fetch_len;
  logic [CLW-1:0] wcol;
  logic [KW-1:0] wr_row, phys;
  logic [KW:0] sum;
  logic [2:0] r_n, c_n;
  logic [RW-1:0] rows_loaded;
  logic full, fetching, fetch_done, shift_done, start;

  assign current_state = state;

  // next-state decode plus the next window row/column and shift-register contents
  always_comb begin
    full = rows_loaded == RW'(I);
    fetching = state == PRELOAD || (state == LOAD && !full);
    fetch_len = state == PRELOAD ? CW'(K * I) : CW'(I);
    fetch_done = cnt == fetch_len;
    shift_done = win_row == 3'(K - 1) && win_col == 3'(K - 1);
    state_n = state;
    case (state)
      INIT:    state_n = cmd == 2'd1 ? PRELOAD : INIT;
      PRELOAD: state_n = fetch_done ? IDLE : PRELOAD;
      SHIFT:   state_n = shift_done ? BIAS : SHIFT;
      BIAS:    state_n = cmd == 2'd2 ? SHIFT : cmd == 2'd3 ? LOAD : IDLE;
      LOAD:    state_n = (full || fetch_done) ? IDLE : LOAD;
      IDLE:    state_n = cmd == 2'd1 ? PRELOAD : cmd == 2'd3 ? LOAD :
                         (cmd == 2'd2 && rows_loaded >= RW'(K)) ? SHIFT : IDLE;
      default: state_n = INIT;
    endcase
    start = state_n == SHIFT && state != SHIFT;
    c_n = (start || win_col == 3'(K - 1)) ? 3'd0 : win_col + 3'd1;
    r_n = start ? 3'd0 : win_row + 3'(win_col == 3'(K - 1));
    sum = {1'b0, wr_row} + (KW+1)'(r_n);
    phys = sum >= (KW+1)'(K) ? KW'(sum - (KW+1)'(K)) : KW'(sum);
    sr_n = c_n == 3'd0 ? buffer[phys] : sr << W;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else if (enable) state <= state_n;
  end

  // fetch, line-buffer fill, window streaming and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) buffer[i] <= '0;
      sr <= '0;
      cnt <= '0;
      wcol <= '0;
      wr_row <= '0;
      rows_loaded <= '0;
      ack <= 2'd0;
      rom_addr <= '0;
      out_valid <= 1'b0;
      win_row <= 3'd0;
      win_col <= 3'd0;
      image_done <= 1'b0;
      out_kernel_port <= '0;
    end else if (enable) begin
      ack <= 2'd0;
      out_valid <= 1'b0;
      out_kernel_port <= '0;
      win_row <= 3'd0;
      win_col <= 3'd0;
      cnt <= (fetching && state_n == state) ? cnt + 1'b1 : '0;
      if (state_n == SHIFT) begin
        sr <= sr_n;
        out_kernel_port <= sr_n[I*W-1 -: ARRAY_SIZE*W];
        out_valid <= 1'b1;
        win_row <= r_n;
        win_col <= c_n;
      end
      if (state_n == BIAS) begin
        out_kernel_port <= {ARRAY_SIZE{BIAS_VALUE}};
        out_valid <= 1'b1;
        ack <= 2'd2;
      end
      if (fetching && cnt != '0) begin
        buffer[wr_row][(I - 1 - int'(wcol)) * W +: W] <= pixel_in;
        wcol <= wcol == CLW'(I - 1) ? '0 : wcol + 1'b1;
        if (wcol == CLW'(I - 1)) wr_row <= wr_row == KW'(K - 1) ? '0 : wr_row + 1'b1;
      end
      if (fetching && cnt < fetch_len && rom_addr != ADDR_MAX) rom_addr <= rom_addr + 1'b1;
      if (fetching && fetch_done) begin
        ack <= state == PRELOAD ? 2'd1 : 2'd3;
        rows_loaded <= state == PRELOAD ? RW'(K) : rows_loaded + 1'b1;
      end
      if (state == LOAD && full) begin
        ack <= 2'd3;
        image_done <= 1'b1;
      end
      if (state_n == PRELOAD && state != PRELOAD) begin
        for (int i = 0; i < K; i++) buffer[i] <= '0;
        rows_loaded <= '0;
        image_done <= 1'b0;
        rom_addr <= '0;
        wr_row <= '0;
        wcol <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_layer_window_feeder.sv
// tb_conv_layer_window_feeder: directed test of the line-buffer window feeder with a ROM holding word a at address a
module tb_conv_layer_window_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic [1:0] cmd = 2'd0;
  logic [31:0] pixel_in = '0;
  logic [1:0] ack;
  logic [2:0] current_state;
  logic [5:0] rom_addr;
  logic out_valid;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic image_done;
  logic [191:0] out_kernel_port;
  int n_chk = 0;
  int n_fail = 0;

  conv_layer_window_feeder dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd(cmd), .pixel_in(pixel_in),
    .ack(ack), .current_state(current_state), .rom_addr(rom_addr), .out_valid(out_valid),
    .win_row(win_row), .win_col(win_col), .image_done(image_done), .out_kernel_port(out_kernel_port)
  );

  always #5 clk = ~clk;

  // synchronous ROM: data for an address appears the cycle after it is presented
  always @(posedge clk) if (enable) pixel_in <= 32'(rom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] lanes(input int v);
    logic [191:0] r;
    for (int j = 0; j < 6; j++) r[(5 - j) * 32 +: 32] = 32'(v + j);
    return r;
  endfunction

  task automatic do_shift(input int base, input bit freeze);
    int v;
    cmd = 2'd2;
    step();
    cmd = 2'd0;
    for (int t = 0; t < 9; t++) begin
      if (t > 0) step();
      v = base + (t / 3) * 8 + t % 3;
      chk("shift_lanes", out_kernel_port, lanes(v));
      chk("shift_valid", 192'(out_valid), 192'd1);
      chk("shift_row", 192'(win_row), 192'(t / 3));
      chk("shift_col", 192'(win_col), 192'(t % 3));
      if (freeze && t == 4) begin
        enable = 1'b0;
        repeat (5) begin
          step();
          chk("freeze_lanes", out_kernel_port, lanes(v));
          chk("freeze_col", 192'(win_col), 192'd1);
          chk("freeze_state", 192'(current_state), 192'd2);
        end
        enable = 1'b1;
      end
    end
    step();
    chk("bias_lanes", out_kernel_port, {6{32'h3F800000}});
    chk("bias_ack", 192'(ack), 192'd2);
    chk("bias_state", 192'(current_state), 192'd3);
    chk("bias_valid", 192'(out_valid), 192'd1);
    step();
    chk("post_bias_state", 192'(current_state), 192'd5);
    chk("post_bias_valid", 192'(out_valid), 192'd0);
    chk("post_bias_lanes", out_kernel_port, 192'd0);
    chk("post_bias_ack", 192'(ack), 192'd0);
  endtask

  task automatic do_load();
    cmd = 2'd3;
    step();
    chk("load_state", 192'(current_state), 192'd4);
    cmd = 2'd0;
    repeat (8) begin
      step();
      chk("load_busy", 192'(current_state), 192'd4);
      chk("load_no_ack", 192'(ack), 192'd0);
    end
    step();
    chk("load_ack", 192'(ack), 192'd3);
    chk("load_idle", 192'(current_state), 192'd5);
    step();
    chk("load_ack_pulse", 192'(ack), 192'd0);
  endtask

  initial begin
    repeat (2) step();
    chk("rst_state", 192'(current_state), 192'd0);
    chk("rst_ack", 192'(ack), 192'd0);
    chk("rst_addr", 192'(rom_addr), 192'd0);
    chk("rst_valid", 192'(out_valid), 192'd0);
    chk("rst_lanes", out_kernel_port, 192'd0);
    chk("rst_done", 192'(image_done), 192'd0);
    rst_n = 1'b1;
    cmd = 2'd2;
    step();
    chk("init_ignores_shift", 192'(current_state), 192'd0);
    cmd = 2'd1;
    step();
    chk("preload_state", 192'(current_state), 192'd1);
    chk("preload_addr0", 192'(rom_addr), 192'd0);
    cmd = 2'd0;
    for (int k = 1; k < 24; k++) begin
      step();
      chk("preload_addr", 192'(rom_addr), 192'(k));
      chk("preload_no_ack", 192'(ack), 192'd0);
    end
    step();
    chk("preload_addr24", 192'(rom_addr), 192'd24);
    chk("preload_last_state", 192'(current_state), 192'd1);
    chk("preload_ack_early", 192'(ack), 192'd0);
    step();
    chk("preload_ack", 192'(ack), 192'd1);
    chk("preload_idle", 192'(current_state), 192'd5);
    step();
    chk("preload_ack_pulse", 192'(ack), 192'd0);
    do_shift(0, 1'b0);
    do_load();
    do_shift(8, 1'b1);
    for (int m = 4; m < 8; m++) begin
      do_load();
      do_shift((m - 2) * 8, 1'b0);
      chk("not_done_yet", 192'(image_done), 192'd0);
    end
    chk("addr_saturated", 192'(rom_addr), 192'd63);
    cmd = 2'd3;
    step();
    chk("final_load_state", 192'(current_state), 192'd4);
    cmd = 2'd0;
    step();
    chk("final_load_ack", 192'(ack), 192'd3);
    chk("final_load_idle", 192'(current_state), 192'd5);
    chk("image_done_set", 192'(image_done), 192'd1);
    step();
    chk("image_done_sticky", 192'(image_done), 192'd1);
    chk("final_ack_pulse", 192'(ack), 192'd0);
    cmd = 2'd1;
    step();
    chk("repreload_state", 192'(current_state), 192'd1);
    chk("image_done_cleared", 192'(image_done), 192'd0);
    chk("repreload_addr", 192'(rom_addr), 192'd0);
    cmd = 2'd0;
    repeat (10) step();
    chk("abort_addr10", 192'(rom_addr), 192'd10);
    rst_n = 1'b0;
    #2;
    chk("async_rst_state", 192'(current_state), 192'd0);
    chk("async_rst_addr", 192'(rom_addr), 192'd0);
    chk("async_rst_ack", 192'(ack), 192'd0);
    chk("async_rst_valid", 192'(out_valid), 192'd0);
    chk("async_rst_lanes", out_kernel_port, 192'd0);
    repeat (3) step();
    chk("held_rst_state", 192'(current_state), 192'd0);
    chk("held_rst_ack", 192'(ack), 192'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_state", 192'(current_state), 192'd0);
    chk("post_rst_ack", 192'(ack), 192'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
